frame_tx: RTL and testbench

FRAME_TX -- requirements
Module: frame_tx

---
 rtl/frame_tx_pkg.sv | 31 +++
 rtl/frame_tx_uart.sv | 59 +++++
 rtl/frame_tx.sv | 157 +++++++++++++++
 tb/tb_frame_tx.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_tx_pkg.sv
// Shared constants for the point-frame transmitter: frame layout bytes,
// byte counts, UART framing and the sequencer state encoding.
package frame_tx_pkg;

  // Frame layout
  localparam int SYNC_LEN = 8;
  localparam int PT_LEN   = 4;
  localparam int TERM_LEN = 4;

  localparam logic [7:0] SYNC_BYTE  = 8'h00;
  localparam logic [7:0] TERM_BYTE  = 8'h01;
  localparam logic [7:0] BRIGHT_ON  = 8'h3F;
  localparam logic [7:0] BRIGHT_OFF = 8'h00;

  // 8N1: start bit + 8 data bits + stop bit
  localparam int FRAME_BITS = 10;

  // Sequencer states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_TERM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // First byte of a point encodes only the brightness flag
  function automatic logic [7:0] bright_byte(input logic on);
    return on ? BRIGHT_ON : BRIGHT_OFF;
  endfunction

endpackage

// File: rtl/frame_tx_uart.sv
// 8N1 UART byte serializer, LSB first. A byte is accepted on i_start while
// idle; o_done is high during the final cycle of the stop bit so the caller
// can queue the next byte with only one idle cycle on the line.
module uart_tx
  import frame_tx_pkg::*;
#(
  parameter int clks_per_bit = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_serial,
  output logic       o_active,
  output logic       o_done
);

  localparam int CW = $clog2(clks_per_bit + 1);

  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    shreg;
  logic          active;
  logic          bit_end;

  assign bit_end  = (clk_cnt == CW'(clks_per_bit - 1));
  assign o_done   = active && bit_end && (bit_idx == 4'(FRAME_BITS - 1));
  assign o_active = active;
  // Line idles high whenever no byte is in flight, including right after reset
  assign o_serial = active ? shreg[0] : 1'b1;

  // Bit-period timing and bit position (control)
  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (!active) begin
      if (i_start) begin
        active  <= 1'b1;
        clk_cnt <= '0;
        bit_idx <= '0;
      end
    end else if (bit_end) begin
      clk_cnt <= '0;
      if (bit_idx == 4'(FRAME_BITS - 1)) active <= 1'b0;
      else                               bit_idx <= bit_idx + 4'd1;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  // Shift register holding {stop, data, start}; bit 0 is on the line
  always_ff @(posedge clk) begin
    if (!active && i_start)    shreg <= {1'b1, i_byte, 1'b0};
    else if (active && bit_end) shreg <= {1'b1, shreg[9:1]};
  end

endmodule

// File: rtl/frame_tx.sv
// Point-frame sequencer: sends 8 sync bytes, N four-byte points read from an
// external synchronous RAM, then 4 terminator bytes over a UART.
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter int index_bits   = 11,
  parameter int max_points   = 2000,
  parameter int clks_per_bit = 87
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [index_bits-1:0] num_points,
  output logic [index_bits-1:0] read_address,
  input  logic [24:0]           point,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  // One extra bit so a full buffer count does not wrap
  localparam int IW1 = index_bits + 1;
  localparam logic [IW1-1:0] MAX_N = IW1'(max_points);

  logic [2:0]     state;
  logic [2:0]     byte_cnt;
  logic [IW1-1:0] pt_cnt;
  logic [IW1-1:0] pt_next;
  logic [IW1-1:0] n_lat;
  logic [23:0]    pt_xy;
  logic [7:0]     tx_byte;
  logic           start_q;
  logic           u_active;
  logic           u_done;

  assign pt_next = pt_cnt + 1'b1;

  function automatic logic [IW1-1:0] clamp_n(input logic [index_bits-1:0] n);
    if ({1'b0, n} > MAX_N) return MAX_N;
    return {1'b0, n};
  endfunction

  uart_tx #(
    .clks_per_bit(clks_per_bit)
  ) u_uart (
    .clk     (clk),
    .reset   (reset),
    .i_start (start_q),
    .i_byte  (tx_byte),
    .o_serial(tx),
    .o_active(u_active),
    .o_done  (u_done)
  );

  // Frame sequencer: each byte is queued in the last stop-bit cycle of the previous one
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      start_q      <= 1'b0;
      byte_cnt     <= '0;
      pt_cnt       <= '0;
      n_lat        <= '0;
      read_address <= '0;
    end else begin
      start_q <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_lat        <= clamp_n(num_points);
            busy         <= 1'b1;
            byte_cnt     <= '0;
            pt_cnt       <= '0;
            read_address <= '0;
            tx_byte      <= SYNC_BYTE;
            start_q      <= 1'b1;
            state        <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (u_done) begin
            if (byte_cnt == 3'(SYNC_LEN - 1)) begin
              byte_cnt <= '0;
              if (n_lat == '0) begin
                tx_byte <= TERM_BYTE;
                start_q <= 1'b1;
                state   <= S_TERM;
              end else begin
                state <= S_FETCH;
              end
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              tx_byte  <= SYNC_BYTE;
              start_q  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          // read_address has been stable for a full byte time, so point is valid here
          if (!u_active) begin
            pt_xy    <= point[23:0];
            tx_byte  <= bright_byte(point[24]);
            start_q  <= 1'b1;
            byte_cnt <= '0;
            state    <= S_POINT;
          end
        end
        S_POINT: begin
          if (u_done) begin
            if (byte_cnt == 3'(PT_LEN - 1)) begin
              byte_cnt <= '0;
              pt_cnt   <= pt_next;
              if (pt_next == n_lat) begin
                tx_byte <= TERM_BYTE;
                start_q <= 1'b1;
                state   <= S_TERM;
              end else begin
                state <= S_FETCH;
              end
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              start_q  <= 1'b1;
              case (byte_cnt)
                3'd0:    tx_byte <= pt_xy[23:16];
                3'd1:    tx_byte <= pt_xy[15:8];
                default: tx_byte <= pt_xy[7:0];
              endcase
              // The point is latched; advance the address early so the next
              // fetch sees settled RAM data
              if (byte_cnt == 3'd2 && pt_next != n_lat)
                read_address <= pt_next[index_bits-1:0];
            end
          end
        end
        S_TERM: begin
          if (u_done) begin
            if (byte_cnt == 3'(TERM_LEN - 1)) begin
              byte_cnt <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              tx_byte  <= TERM_BYTE;
              start_q  <= 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// Self-checking bench for frame_tx: a UART decoder on tx feeds every byte to a
// queue-based model of the expected frame; a per-cycle monitor checks
// busy/done/tx relations and frame timing bounds.
module tb_frame_tx;

  localparam int CPB  = 4;
  localparam int IB   = 6;
  localparam int MAXP = 40;

  logic          clk;
  logic          reset;
  logic          start;
  logic [IB-1:0] num_points;
  logic [IB-1:0] read_address;
  logic [24:0]   point;
  logic          tx;
  logic          busy;
  logic          done;

  logic [24:0] ram [0:(1<<IB)-1];

  int vectors;
  int miscompares;

  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  int busy_cycles;
  int done_cnt;
  int max_addr;
  bit dec_abort;

  bit         rx_busy;
  int         rx_cnt;
  int         dec_k;
  logic [7:0] rx_bits;

  logic [7:0] lit2 [12] = '{8'h3F, 8'h12, 8'h34, 8'h56, 8'h00, 8'hAB, 8'hCD, 8'hEF,
                            8'h01, 8'h01, 8'h01, 8'h01};

  frame_tx #(
    .index_bits  (IB),
    .max_points  (MAXP),
    .clks_per_bit(CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_points  (num_points),
    .read_address(read_address),
    .point       (point),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous point RAM: data one cycle after the address
  always @(posedge clk) point <= ram[read_address];

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Expected byte stream straight from the frame rules
  task automatic build_expected(input int n);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(ram[k][24] ? 8'h3F : 8'h00);
      exp_q.push_back(ram[k][23:16]);
      exp_q.push_back(ram[k][15:8]);
      exp_q.push_back(ram[k][7:0]);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h01);
  endtask

  task automatic randomize_ram();
    for (int i = 0; i < (1 << IB); i++) ram[i] = 25'($urandom);
  endtask

  // UART receiver: samples mid-bit and checks each byte against the model queue
  always @(negedge clk) begin
    if (dec_abort) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB / 2 && ((rx_cnt - CPB / 2) % CPB) == 0) begin
        dec_k = (rx_cnt - CPB / 2) / CPB;
        if (dec_k == 0) begin
          check("start_bit", tx, 0);
        end else if (dec_k <= 8) begin
          rx_bits[dec_k-1] = tx;
        end else begin
          check("stop_bit", tx, 1);
          rx_log.push_back(rx_bits);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got %02h, required no byte", rx_bits);
          end else begin
            check("byte_stream", rx_bits, exp_q.pop_front());
          end
          rx_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle monitor of the control outputs
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (busy === 1'b1) begin
        busy_cycles++;
        if (int'(read_address) > max_addr) max_addr = int'(read_address);
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("busy_low_at_done", busy, 0);
      end
      if (busy === 1'b0) check("tx_idle_high", tx, 1);
    end
  end

  task automatic start_frame(input int n_req);
    @(negedge clk);
    busy_cycles = 0;
    done_cnt    = 0;
    max_addr    = 0;
    rx_log.delete();
    start      = 1'b1;
    num_points = IB'(n_req);
    @(negedge clk);
    start      = 1'b0;
    num_points = IB'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_frame(input int n, input bit quick);
    int  nbytes;
    int  lim;
    bit  seen;
    nbytes = 12 + 4 * n;
    lim    = nbytes * (10 * CPB + 2) + 20;
    seen   = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", lim);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      return;
    end
    check("bytes_left", exp_q.size(), 0);
    check_range("busy_len", busy_cycles, nbytes * 10 * CPB, nbytes * (10 * CPB + 2));
    check("max_read_address", max_addr, (n > 0) ? n - 1 : 0);
    if (!quick) begin
      repeat (3) @(negedge clk);
      check("done_count", done_cnt, 1);
      check("frame_bytes", rx_log.size(), nbytes);
    end
  endtask

  initial begin
    int recv_n;
    int n;
    bit hit;
    logic [24:0] rp;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    num_points  = '0;
    dec_abort   = 1'b0;
    rx_busy     = 1'b0;
    busy_cycles = 0;
    done_cnt    = 0;
    max_addr    = 0;
    randomize_ram();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read_address", read_address, 0);
    reset = 1'b0;
    @(negedge clk);

    // Empty frame: 12 bytes, fixed timing window
    build_expected(0);
    check("model_len_n0", exp_q.size(), 12);
    start_frame(0);
    finish_frame(0, 1'b0);
    for (int i = 0; i < 12; i++) check("n0_byte", rx_log[i], (i < 8) ? 8'h00 : 8'h01);
    check_range("n0_busy_len", busy_cycles, 480, 504);

    // Two known points
    ram[0] = 25'h1_123456;
    ram[1] = 25'h0_ABCDEF;
    build_expected(2);
    for (int i = 0; i < 12; i++) check("model_n2_byte", exp_q[8+i], lit2[i]);
    start_frame(2);
    finish_frame(2, 1'b0);
    for (int i = 0; i < 12; i++) check("n2_byte", rx_log[8+i], lit2[i]);

    // Start re-pulsed mid-frame is ignored
    randomize_ram();
    build_expected(3);
    start_frame(3);
    repeat (48) @(negedge clk);
    start      = 1'b1;
    num_points = IB'($urandom);
    @(negedge clk);
    start = 1'b0;
    finish_frame(3, 1'b0);
    repeat (60) @(negedge clk);
    check("no_queued_frame_busy", busy, 0);
    check("no_queued_frame_done", done_cnt, 1);

    // Reset in the middle of a data bit of byte 5
    randomize_ram();
    build_expected(3);
    start_frame(3);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (rx_log.size() == 5) hit = 1'b1;
    end
    check("reached_byte5", hit, 1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (tx === 1'b0) hit = 1'b1;
    end
    check("byte5_started", hit, 1);
    repeat (2 * CPB + CPB / 2) @(negedge clk);
    reset     = 1'b1;
    dec_abort = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_read_address", read_address, 0);
    reset = 1'b0;
    @(negedge clk);
    dec_abort = 1'b0;
    exp_q.delete();
    repeat (12 * CPB) @(negedge clk);
    check("abort_no_done", done_cnt, 0);

    // Fresh frame after the abort, decoded as a receiver would store it
    randomize_ram();
    build_expected(3);
    start_frame(3);
    finish_frame(3, 1'b1);
    recv_n = (rx_log.size() - 12) / 4;
    check("loop_num_points", recv_n, 3);
    for (int k = 0; k < 3; k++) begin
      rp = {(rx_log[8+4*k] == 8'h3F), rx_log[9+4*k], rx_log[10+4*k], rx_log[11+4*k]};
      check("loop_point", rp, ram[k]);
    end

    // Start on the cycle right after done
    build_expected(1);
    start_frame(1);
    finish_frame(1, 1'b0);

    // Oversized count clamps to the buffer capacity
    randomize_ram();
    build_expected(MAXP);
    start_frame((1 << IB) - 1);
    finish_frame(MAXP, 1'b0);

    // Reset wins over start in the same cycle
    @(negedge clk);
    reset      = 1'b1;
    start      = 1'b1;
    num_points = IB'(5);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("reset_priority_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("reset_priority_idle", busy, 0);

    // Random point counts
    for (int r = 0; r < 4; r++) begin
      randomize_ram();
      n = $urandom_range(0, 6);
      build_expected(n);
      start_frame(n);
      finish_frame(n, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
